// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the multi-cycle data-memory responder.
// Optional feature macro: DMEM_ERR_EN (adds the mem_err error pulse).
package data_mem_responder_pkg;

  // Responder handshake states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wait-state counter width; covers LATENCY up to 15.
  localparam int CNT_W = 4;

  // Default geometry.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LATENCY    = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage request/response bundle between the EX/MEM register (master)
// and the data-memory responder (slave).
// Optional feature macro: DMEM_ERR_EN (adds mem_err to the bundle).
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  mem_ready;
`ifdef DMEM_ERR_EN
  logic                  mem_err;
`endif

`ifdef DMEM_ERR_EN
  modport master (
    output MemRead, MemWrite, address, WriteData,
    input  ReadData, mem_ready, mem_err
  );
  modport slave (
    input  MemRead, MemWrite, address, WriteData,
    output ReadData, mem_ready, mem_err
  );
`else
  modport master (
    output MemRead, MemWrite, address, WriteData,
    input  ReadData, mem_ready
  );
  modport slave (
    input  MemRead, MemWrite, address, WriteData,
    output ReadData, mem_ready
  );
`endif

endinterface

// File: rtl/data_mem_responder_array.sv
// DEPTH x DATA_WIDTH word storage: synchronous write, asynchronous read.
module data_mem_responder_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Word write on the clock edge.
  // NOTE: the array has no reset on purpose; clearing it would turn the RAM
  // into DEPTH x DATA_WIDTH resettable flops and its contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. Adds LATENCY wait
// states and drops mem_ready so the hazard logic freezes the pipe.
// Optional feature macro: DMEM_ERR_EN (misaligned / out-of-range / read+write
// requests are suppressed and flagged with a one-cycle mem_err in DONE).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);

  // One captured request; the copy is used while inputs are ignored in BUSY.
  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic                  err;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  req_t                  cap_q,       cap_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  mem_err_q,   mem_err_d;

  req_t                  live_req;
  req_t                  sel_req;
  logic                  req;
  logic                  live_err;
  logic                  commit;
  logic                  mem_we;
  logic                  rd_load;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign req = bus.MemRead | bus.MemWrite;

`ifdef DMEM_ERR_EN
  assign live_err = (bus.address[1:0] != 2'b00)
                  | ((bus.address >> (IW + 2)) != '0)
                  | (bus.MemRead & bus.MemWrite);
`else
  assign live_err = 1'b0;
`endif

  assign live_req = '{rd:    bus.MemRead,
                      wr:    bus.MemWrite,
                      err:   live_err,
                      idx:   bus.address[IW+1:2],
                      wdata: bus.WriteData};

  // With LATENCY=1 the commit edge leaves IDLE, before the capture registers
  // load, so the live inputs are used in IDLE and the captured copy otherwise.
  assign sel_req = (state_q == IDLE) ? live_req : cap_q;

  // The edge entering DONE commits the access.
  assign commit = ((state_q == IDLE) && req && (LATENCY == 1))
               || ((state_q == BUSY) && (cnt_q == '0));

  // Both-set requests count as writes; error requests touch nothing.
  assign mem_we  = commit & sel_req.wr & ~sel_req.err;
  assign rd_load = commit & sel_req.rd & ~sel_req.wr & ~sel_req.err;

  data_mem_responder_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (sel_req.idx),
    .wdata (sel_req.wdata),
    .rdata (arr_rdata)
  );

  // Next-state logic for the handshake FSM, capture and result registers.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    read_data_d = rd_load ? arr_rdata : read_data_q;
    mem_err_d   = commit & sel_req.err;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cap_d = live_req;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      read_data_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      read_data_q <= read_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Combinational so the pipe stalls in the very cycle a request appears.
  assign bus.mem_ready = ((state_q == IDLE) && !req) || (state_q == DONE);
  assign bus.ReadData  = read_data_q;
`ifdef DMEM_ERR_EN
  assign bus.mem_err   = mem_err_q;
`endif

  // Address bits outside the word index only matter to the error check.
  logic unused_sink;
  assign unused_sink = ^{bus.address[1:0], bus.address >> (IW + 2), mem_err_q};

endmodule
